// File: rtl/mem_if_ctrl.sv
// Handshake controller between the TSC datapath (readM/writeM) and a synchronous single-port SRAM.
// Optional one-entry last-read bypass buffer, compiled in when MEM_IF_BYPASS_EN is defined.
module mem_if_ctrl #(
  parameter int WORD_SIZE   = 16,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 inputReady,
  output logic                 ackOutput,
  output logic                 sram_ce,
  output logic                 sram_we,
  output logic [ADDR_W-1:0]    sram_addr,
  output logic [WORD_SIZE-1:0] sram_wdata,
  input  logic [WORD_SIZE-1:0] sram_rdata
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_ACCESS, RD_CAPTURE, RD_HOLD, WR_WAIT, WR_ACCESS, WR_ACK
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [WORD_SIZE-1:0]   rd_data_q;
  logic                   cap_vld_p0;
  logic                   byp_hit;
  logic                   unused_addr_hi;

  assign unused_addr_hi = ^address[WORD_SIZE-1:ADDR_W];

`ifdef MEM_IF_BYPASS_EN
  logic                   byp_vld_q;
  logic [ADDR_W-1:0]      byp_tag_q;
  logic [WORD_SIZE-1:0]   byp_data_q;

  assign byp_hit = byp_vld_q && (byp_tag_q == address[ADDR_W-1:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byp_vld_q  <= 1'b0;
      byp_tag_q  <= '0;
      byp_data_q <= '0;
    end else if (cap_vld_p0) begin
      byp_vld_q  <= 1'b1;
      byp_tag_q  <= sram_addr;
      byp_data_q <= sram_rdata;
    end else if (state_q == WR_ACCESS && byp_vld_q && byp_tag_q == sram_addr) begin
      byp_data_q <= sram_wdata;
    end
  end
`else
  assign byp_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (readM) begin
          cnt_d = WS;
          if (byp_hit)         state_d = RD_HOLD;
          else if (WS == 4'd0) state_d = RD_ACCESS;
          else                 state_d = RD_WAIT;
        end else if (writeM) begin
          cnt_d   = WS;
          state_d = (WS == 4'd0) ? WR_ACCESS : WR_WAIT;
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RD_ACCESS;
      end
      RD_ACCESS:  state_d = RD_CAPTURE;
      RD_CAPTURE: state_d = RD_HOLD;
      RD_HOLD:    if (!readM) state_d = IDLE;
      WR_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = WR_ACCESS;
      end
      WR_ACCESS:  state_d = WR_ACK;
      WR_ACK:     if (!writeM) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Every output is registered from the current state, so a state's strobe
  // appears in the cycle after it; hold/ack drop on the same edge that exits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      inputReady <= 1'b0;
      ackOutput  <= 1'b0;
      sram_ce    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      rd_data_q  <= '0;
      cap_vld_p0 <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sram_ce    <= (state_q == RD_ACCESS) || (state_q == WR_ACCESS);
      sram_we    <= (state_q == WR_ACCESS);
      cap_vld_p0 <= (state_q == RD_CAPTURE);
      inputReady <= (state_q == RD_HOLD) && readM;
      ackOutput  <= (state_q == WR_ACK) && writeM;
      if (state_q == IDLE && (readM || writeM))
        sram_addr <= address[ADDR_W-1:0];
      if (state_q == IDLE && !readM && writeM)
        sram_wdata <= data;
      // SRAM data is valid the cycle after the strobe, one behind RD_CAPTURE
      if (cap_vld_p0)
        rd_data_q <= sram_rdata;
`ifdef MEM_IF_BYPASS_EN
      else if (state_q == IDLE && readM && byp_hit)
        rd_data_q <= byp_data_q;
`endif
    end
  end

  assign data = inputReady ? rd_data_q : {WORD_SIZE{1'bz}};

endmodule

// File: doc/mem_if_ctrl.md
# mem_if_ctrl

- Memory-side handshake controller for the 16-bit TSC datapath.
- Converts the datapath's level-sensitive `readM`/`writeM` request protocol into single-cycle accesses on a synchronous single-port SRAM.
- Inserts a programmable number of wait states.
- Returns read data with `inputReady` and write completion with `ackOutput`.
- Sits directly downstream of the datapath, between it and the memory array. It services both instruction fetch and load/store traffic.

## Interface
- `WORD_SIZE`, 16, data/address width on the datapath side.
- `ADDR_W`, 8, SRAM word-address width (256 words).
- `WAIT_STATES`, 2, idle cycles inserted before each SRAM access; legal range 0..15.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `readM`  in  1  read request, level; held by the datapath until `inputReady` is seen.
- `writeM`  in  1  write request, level; held until `ackOutput` is seen.
- `address`  in  WORD_SIZE  word address; latched when a request is accepted.
- `data`  inout  WORD_SIZE  driven by this block only while `inputReady`=1, otherwise Z; write data is sampled from it at acceptance.
- `inputReady`  out  1  read data valid on `data`.
- `ackOutput`  out  1  write complete.
- `sram_ce`  out  1  SRAM access strobe, one cycle per access.
- `sram_we`  out  1  write enable, qualified by `sram_ce`.
- `sram_addr`  out  ADDR_W  latched `address[ADDR_W-1:0]`.
- `sram_wdata`  out  WORD_SIZE  latched write data.
- `sram_rdata`  in  WORD_SIZE  SRAM read data, valid the cycle after the `sram_ce` read cycle.

## Operation
- Address translation: upper `address` bits above `ADDR_W` are ignored, so addresses wrap modulo 2^ADDR_W.
- States: IDLE, RD_WAIT, RD_ACCESS, RD_CAPTURE, RD_HOLD, WR_WAIT, WR_ACCESS, WR_ACK.
- IDLE:
  - If `readM`=1: latch the address and load the wait counter with `WAIT_STATES`.
    - Go to RD_WAIT, or to RD_ACCESS if `WAIT_STATES`=0.
  - Else if `writeM`=1: latch the address and `data`, and load the counter.
    - Go to WR_WAIT, or to WR_ACCESS if `WAIT_STATES`=0.
  - If both are high, the read wins; the write stays pending and is accepted from IDLE after the read completes.
- RD_WAIT / WR_WAIT: decrement the counter; on the cycle it reaches 1, advance to the matching ACCESS state.
- RD_ACCESS: `sram_ce`=1, `sram_we`=0 for one cycle; then RD_CAPTURE.
- RD_CAPTURE: register `sram_rdata` into the read-data register; then RD_HOLD.
- RD_HOLD:
  - `inputReady`=1 and the read-data register is driven onto `data`.
  - Stay while `readM`=1.
  - On `readM`=0, go to IDLE; `inputReady` and the `data` drive drop after that edge.
- WR_ACCESS: `sram_ce`=1, `sram_we`=1 for one cycle; then WR_ACK.
- WR_ACK: `ackOutput`=1 while `writeM`=1; on `writeM`=0, go to IDLE.
- Request drop before completion: the access still completes, and the hold/ack state exits on the next sampled low.
- Reset (asynchronous, also mid-operation):
  - state goes to IDLE;
  - `inputReady`, `ackOutput`, `sram_ce`, `sram_we` = 0;
  - `sram_addr`, `sram_wdata` and the read-data register = 0;
  - `data` = Z;
  - counter = 0;
  - bypass entry invalidated.
  - An in-flight SRAM access is abandoned.

## Timing
- Edge E0 is the edge at which IDLE samples a request.
- Read (miss): `inputReady` rises after edge E0+WAIT_STATES+3, giving 5 cycles at default.
- Write: `sram_ce`/`sram_we` are high in the cycle following E0+WAIT_STATES+1; `ackOutput` rises after edge E0+WAIT_STATES+2.
- Exactly one `sram_ce` cycle per accepted request.
- `inputReady`, `ackOutput`, `sram_*` and the `data` drive are all registered outputs, with no combinational path from inputs.
- Minimum 1 IDLE cycle between consecutive requests.

## Configuration
- `MEM_IF_BYPASS_EN` defined:
  - A one-entry last-read buffer (valid, ADDR_W tag, WORD_SIZE data) is compiled in.
  - Read hit in IDLE: no SRAM access; go directly to RD_HOLD, so `inputReady` rises after edge E0+1.
  - Every completed read miss fills the entry.
  - A write to the tagged address updates the entry's data at WR_ACCESS.
  - Reset clears valid.
- `MEM_IF_BYPASS_EN` not defined: no buffer; every read takes full latency.

## Test plan
- Reset, write 16'h1234 to address 5, read address 5 → `ackOutput` after E0+4; read returns 16'h1234 with `inputReady` after E0+5; one `sram_ce` per request.
- `WAIT_STATES`=0, read of preloaded address 0 = 16'hBEEF → `inputReady` after E0+3; `data` = Z again the cycle after `readM` drops.
- `readM` and `writeM` raised together (write 16'h00AA to address 3, read address 3 of old value 16'h0011) → read served first and returns 16'h0011; then the write; `ackOutput` follows.
- Address 16'h0107 with `ADDR_W`=8 → `sram_addr`=8'h07.
- `reset_n` pulsed low during RD_WAIT → outputs 0 immediately; `data` Z; no `sram_ce`; a subsequent read completes normally.
- With `MEM_IF_BYPASS_EN`: two back-to-back reads of address 9 → second `inputReady` after E0+1 with no `sram_ce`. Then write 16'h5555 to address 9 and re-read → bypass hit returns 16'h5555.
